serial_subtractor_4_bit: RTL
============================

SERIAL_SUBTRACTOR_4_BIT -- requirements
Module: serial_subtractor_4_bit

Interface
REQ-001 SHALL have parameter WIDTH, default 4, meaning operand and result width in bits; all cycle counts below scale with WIDTH.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request a subtraction; sampled only in IDLE.
REQ-005 SHALL have port A  input  WIDTH  minuend; unsigned.
REQ-006 SHALL have port B  input  WIDTH  subtrahend; unsigned.
REQ-007 SHALL have port D  output  WIDTH  registered difference (A - B) mod 2^WIDTH.
REQ-008 SHALL have port B_out  output  1  registered final borrow; 1 iff A < B unsigned.
REQ-009 SHALL have port Z  output  1  registered zero flag; 1 iff D == 0.
REQ-010 SHALL have port busy  output  1  high while a subtraction is in progress.
REQ-011 SHALL have port done  output  1  one-cycle pulse marking a new D/B_out/Z.

Function
REQ-012 SHALL implement FSM states IDLE, RUN, DONE.
REQ-013 IDLE: start=1 at an edge SHALL latch A and B into internal shift registers, clear the borrow flip-flop, clear the bit counter, and move to RUN; start=0 SHALL keep IDLE.
REQ-014 RUN SHALL process one bit per clock, LSB first: d = a XOR b XOR bw; bw_next = (NOT a AND b) OR (NOT (a XOR b) AND bw).
REQ-015 Each RUN edge SHALL shift the operand registers right by one and shift d into the result shift register from the MSB end.
REQ-016 RUN SHALL last exactly WIDTH clocks; on the WIDTH-th RUN edge the FSM SHALL move to DONE.
REQ-017 The same edge SHALL load D from the completed result, B_out from the final borrow, and Z from (result == 0).
REQ-018 DONE SHALL last exactly one clock, then return to IDLE unconditionally.
REQ-019 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only; both are decoded from registered state.
REQ-020 Latency: start sampled at edge 0 SHALL give done=1 between edge WIDTH and edge WIDTH+1 (4 clocks after start for WIDTH=4).
REQ-021 start in RUN or DONE SHALL be ignored; it is not queued.
REQ-022 A and B changes after the start edge SHALL NOT affect the result in progress.
REQ-023 D, B_out and Z SHALL hold their last values between completions, including through IDLE and the next RUN.
REQ-024 Back-to-back: start held high SHALL begin a new operation on the first IDLE edge after DONE, giving one result per WIDTH+2 clocks.
REQ-025 Arithmetic SHALL wrap modulo 2^WIDTH with no saturation; A == B SHALL give D=0, B_out=0, Z=1.

Reset
REQ-026 rst_n=0 SHALL immediately, independent of clk, force IDLE, D=0, B_out=0, Z=0, busy=0, done=0, and clear the counter, borrow and shift registers.
REQ-027 Reset during RUN or DONE SHALL abandon the operation; no done pulse SHALL follow, and D/B_out/Z SHALL read 0.
REQ-028 After rst_n deasserts, the first rising edge with start=1 SHALL begin a new operation normally.

Verification
REQ-029 A=9, B=5, start pulse -> busy for 4 clocks, then done pulse with D=4, B_out=0, Z=0.
REQ-030 A=5, B=9 -> D=12 (0xC), B_out=1, Z=0; A=0, B=1 -> D=15, B_out=1, Z=0.
REQ-031 A=7, B=7 -> D=0, B_out=0, Z=1; A=0, B=0 -> D=0, B_out=0, Z=1.
REQ-032 start pulse during RUN and during DONE, and A/B changed mid-RUN -> exactly one done pulse, with the result of the originally latched operands.
REQ-033 rst_n low for a partial cycle during RUN -> outputs 0 asynchronously, no done pulse; next start with A=3, B=1 -> D=2, B_out=0.
REQ-034 start held high for 20 clocks with random operands -> done every 6 clocks; every D/B_out/Z matches a (A - B) mod 16 reference model; exhaustive sweep of all 256 A/B pairs passes.

Source files
------------

// File: rtl/serial_subtractor_4_bit.sv
// rtl/serial_subtractor_4_bit.sv - bit-serial unsigned subtractor, LSB first, with borrow and zero flags
module serial_subtractor_4_bit #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] D,
  output logic             B_out,
  output logic             Z,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic             bw_q, bw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             z_q, z_d;

  logic             a_bit, b_bit, d_bit, bw_next;
  logic [WIDTH:0]   r_cat;
  logic [WIDTH-1:0] r_shift;

  // One full-subtractor slice working on the current LSBs of the operand shift registers
  always_comb begin
    a_bit   = a_q[0];
    b_bit   = b_q[0];
    d_bit   = a_bit ^ b_bit ^ bw_q;
    bw_next = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);
    r_cat   = {d_bit, r_q};
    r_shift = r_cat[WIDTH:1];
  end

  // Next-state: latch operands on start, walk WIDTH bits, publish result on the last bit
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
    z_d     = z_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = r_shift;
        bw_d  = bw_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          diff_d  = r_shift;
          bout_d  = bw_next;
          z_d     = (r_shift == '0);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any operation and clears the published result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
      z_q     <= z_d;
    end
  end

  // Status decoded straight from the registered state
  always_comb begin
    busy  = (state_q == RUN);
    done  = (state_q == DONE);
    D     = diff_q;
    B_out = bout_q;
    Z     = z_q;
  end

endmodule
